// File: rtl/two_s_complement_pkg.sv
// Shared constants and helpers for the registered two's complement negator.
package two_s_complement_pkg;

    localparam int unsigned TC_WIDTH_DEFAULT = 32'd4;
    localparam int unsigned TC_MAX_WIDTH     = 32'd64;

    // Most-negative pattern (MSB set, rest clear) for a w-bit word, LSB-aligned in a wide word.
    function automatic logic [TC_MAX_WIDTH-1:0] tc_min_neg(input int unsigned w);
        logic [TC_MAX_WIDTH-1:0] one_v;
        one_v = {{(TC_MAX_WIDTH-1){1'b0}}, 1'b1};
        return one_v << (w - 32'd1);
    endfunction

endpackage

// File: rtl/two_s_complement_incrementer.sv
// Ripple increment of the bit-inverted operand: sum_o = ~operand_i + 1, carry_o is the MSB carry.
module tc_incrementer #(
    parameter int unsigned WIDTH = 32'd4
) (
    input  logic [WIDTH-1:0] operand_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    logic [WIDTH-1:0] inv_s;
    logic [WIDTH:0]   carry_s;

    assign inv_s      = ~operand_i;
    assign carry_s[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        assign sum_o[i]     = inv_s[i] ^ carry_s[i];
        assign carry_s[i+1] = inv_s[i] & carry_s[i];
    end

    // Carry survives the whole chain only when the operand was all zeros.
    assign carry_o = carry_s[WIDTH];

endmodule

// File: rtl/two_s_complement.sv
// Registered two's complement negator with valid, most-negative (ovf) and zero flags.
module two_s_complement
    import two_s_complement_pkg::*;
#(
    parameter int unsigned WIDTH = TC_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] In,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Out,
    output logic             out_valid,
    output logic             ovf,
    output logic             zero
);

    localparam logic [TC_MAX_WIDTH-1:0] MIN_NEG_WIDE = tc_min_neg(WIDTH);
    localparam logic [WIDTH-1:0]        MIN_NEG      = MIN_NEG_WIDE[WIDTH-1:0];

    logic [WIDTH-1:0] neg_s;
    logic             carry_s;

    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    tc_incrementer #(.WIDTH(WIDTH)) u_inc (
        .operand_i (In),
        .sum_o     (neg_s),
        .carry_o   (carry_s)
    );

    // Next-state: load a new result on accept, otherwise hold result and flags.
    always_comb begin
        out_d       = out_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            out_d       = neg_s;
            ovf_d       = (In == MIN_NEG);
            zero_d      = carry_s;
            out_valid_d = 1'b1;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // Output registers; synchronous reset wins over an operand in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign Out       = out_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_two_s_complement.sv
// Bench for two_s_complement: arithmetic model checked every cycle plus directed literal vectors.
module tb_two_s_complement;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in4;
    logic       iv4;
    logic [3:0] out4;
    logic       ov4, ovf4, zero4;
    logic [7:0] in8;
    logic       iv8;
    logic [7:0] out8;
    logic       ov8, ovf8, zero8;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state
    logic [3:0] m4_out;
    logic       m4_valid, m4_ovf, m4_zero;
    logic [7:0] m8_out;
    logic       m8_valid, m8_ovf, m8_zero;

    always #10 clk = ~clk;

    two_s_complement #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .In(in4), .in_valid(iv4),
        .Out(out4), .out_valid(ov4), .ovf(ovf4), .zero(zero4)
    );

    two_s_complement #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .In(in8), .in_valid(iv8),
        .Out(out8), .out_valid(ov8), .ovf(ovf8), .zero(zero8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level model: negation is (2^W - x) mod 2^W, flags from the accepted value.
    always @(posedge clk) begin
        if (!rst_n) begin
            m4_out = 4'd0; m4_valid = 1'b0; m4_ovf = 1'b0; m4_zero = 1'b0;
            m8_out = 8'd0; m8_valid = 1'b0; m8_ovf = 1'b0; m8_zero = 1'b0;
        end else begin
            m4_valid = iv4;
            if (iv4) begin
                m4_out  = 4'((16 - int'(in4)) % 16);
                m4_ovf  = (int'(in4) == 8);
                m4_zero = (int'(in4) == 0);
            end
            m8_valid = iv8;
            if (iv8) begin
                m8_out  = 8'((256 - int'(in8)) % 256);
                m8_ovf  = (int'(in8) == 128);
                m8_zero = (int'(in8) == 0);
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m4_out",   32'(out4),  32'(m4_out));
            check("m4_valid", 32'(ov4),   32'(m4_valid));
            check("m4_ovf",   32'(ovf4),  32'(m4_ovf));
            check("m4_zero",  32'(zero4), 32'(m4_zero));
            check("m8_out",   32'(out8),  32'(m8_out));
            check("m8_valid", 32'(ov8),   32'(m8_valid));
            check("m8_ovf",   32'(ovf8),  32'(m8_ovf));
            check("m8_zero",  32'(zero8), 32'(m8_zero));
        end
    end

    task automatic step4(input logic [3:0] v, input logic valid);
        in4 = v;
        iv4 = valid;
        @(negedge clk);
    endtask

    logic [3:0] sweep_exp [16] = '{4'h0, 4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9,
                                   4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        rst_n = 1'b0;
        in4 = 4'd0; iv4 = 1'b0;
        in8 = 8'd0; iv8 = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_out",   32'(out4), 32'h0);
        check("rst_valid", 32'(ov4),  32'h0);
        check("rst_ovf",   32'(ovf4), 32'h0);
        check("rst_zero",  32'(zero4),32'h0);
        rst_n = 1'b1;

        // Exhaustive sweep, one operand per cycle
        for (int i = 0; i < 16; i++) begin
            step4(4'(i), 1'b1);
            check("sweep_out",   32'(out4), 32'(sweep_exp[i]));
            check("sweep_valid", 32'(ov4),  32'h1);
        end

        // Boundaries
        step4(4'h0, 1'b1);
        check("b0_out", 32'(out4), 32'h0); check("b0_zero", 32'(zero4), 32'h1); check("b0_ovf", 32'(ovf4), 32'h0);
        step4(4'h8, 1'b1);
        check("b8_out", 32'(out4), 32'h8); check("b8_ovf", 32'(ovf4), 32'h1); check("b8_zero", 32'(zero4), 32'h0);
        step4(4'h7, 1'b1);
        check("b7_out", 32'(out4), 32'h9); check("b7_ovf", 32'(ovf4), 32'h0);
        step4(4'hF, 1'b1);
        check("bF_out", 32'(out4), 32'h1); check("bF_zero", 32'(zero4), 32'h0);

        // Hold with In toggling (including unknowns) while in_valid is low
        step4(4'h3, 1'b1);
        check("hold_load", 32'(out4), 32'hD);
        step4(4'hA, 1'b0);
        check("hold1_out", 32'(out4), 32'hD); check("hold1_valid", 32'(ov4), 32'h0);
        step4(4'hx, 1'b0);
        check("hold2_out", 32'(out4), 32'hD); check("hold2_valid", 32'(ov4), 32'h0);
        step4(4'h5, 1'b0);
        check("hold3_out", 32'(out4), 32'hD); check("hold3_valid", 32'(ov4), 32'h0);

        // Reset priority over an operand
        step4(4'h5, 1'b1);
        check("pre_rst_out", 32'(out4), 32'hB);
        rst_n = 1'b0;
        step4(4'h2, 1'b1);
        check("rst_mid_out", 32'(out4), 32'h0); check("rst_mid_valid", 32'(ov4), 32'h0);
        rst_n = 1'b1;
        step4(4'h2, 1'b1);
        check("post_rst_out", 32'(out4), 32'hE); check("post_rst_valid", 32'(ov4), 32'h1);
        step4(4'h0, 1'b0);
        check("post_rst_drop", 32'(ov4), 32'h0);

        // WIDTH=8: most-negative pattern, then involution over random operands
        in8 = 8'h80; iv8 = 1'b1;
        @(negedge clk);
        check("w8_min_out", 32'(out8), 32'h80); check("w8_min_ovf", 32'(ovf8), 32'h1);
        in8 = 8'h01;
        @(negedge clk);
        check("w8_01_out", 32'(out8), 32'hFF);
        for (int k = 0; k < 1000; k++) begin
            a = 8'($urandom_range(0, 255));
            in8 = a;
            @(negedge clk);
            b = out8;
            in8 = b;
            @(negedge clk);
            check("involution", 32'(out8), 32'(a));
        end
        iv8 = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/two_s_complement.md
TWO_S_COMPLEMENT -- requirements
Module: two_s_complement

Interface
REQ-001 Parameter WIDTH, default 4, data width in bits (minimum 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 In  input  WIDTH  operand, unsigned bit pattern.
REQ-005 in_valid  input  1  operand qualifier; In sampled only when high.
REQ-006 Out  output  WIDTH  registered two's complement (negation) of last accepted In.
REQ-007 out_valid  output  1  high for one cycle after each accepted operand.
REQ-008 ovf  output  1  registered; high when accepted In was the most-negative pattern (1 followed by WIDTH-1 zeros).
REQ-009 zero  output  1  registered; high when accepted In was all zeros.

Function
REQ-010 On a rising clk edge with rst_n=1 and in_valid=1, Out SHALL load (~In + 1) modulo 2^WIDTH.
REQ-011 Latency SHALL be exactly one cycle from the accepting edge to Out/out_valid/ovf/zero being visible; throughput one operand per cycle.
REQ-012 out_valid SHALL be registered in_valid: high in the cycle after an accept, low otherwise; no backpressure.
REQ-013 With in_valid=0, Out, ovf and zero SHALL hold their previous values.
REQ-014 In=0 SHALL produce Out=0, zero=1, ovf=0; the carry out of the MSB is discarded.
REQ-015 In=2^(WIDTH-1) SHALL produce Out=In (wrap-around), ovf=1, zero=0.
REQ-016 All other inputs SHALL produce ovf=0, zero=0.
REQ-017 Negation SHALL be an involution: feeding Out back as In reproduces the original In.
REQ-018 Outputs SHALL depend only on registered state; no combinational path from In to Out.
REQ-019 X/Z on In while in_valid=0 SHALL NOT affect any output.

Reset
REQ-020 While rst_n=0 at a rising edge: Out=0, out_valid=0, ovf=0, zero=0.
REQ-021 Reset SHALL take priority over in_valid; an operand presented in a reset cycle is discarded.
REQ-022 Reset asserted mid-stream SHALL clear outputs on the next edge; the first accept after release produces a result one cycle later.

Structure
REQ-023 A shared package SHALL hold the default WIDTH constant and a function/constant for the most-negative pattern (MIN_NEG).
REQ-024 One sub-module, tc_incrementer (WIDTH-bit ripple increment of the inverted operand, with carry out), SHALL implement the arithmetic; the top holds the output registers and flag logic.
REQ-025 No behavioural unary minus is required; the inverter+incrementer structure is the reference implementation.

Verification
REQ-026 Exhaustive sweep, WIDTH=4: In=0..15, one per 20 ns with in_valid=1 -> Out one cycle later equals 0,F,E,D,C,B,A,9,8,7,6,5,4,3,2,1.
REQ-027 Boundaries: In=0 -> Out=0, zero=1, ovf=0; In=8 -> Out=8, ovf=1; In=7 -> Out=9, ovf=0; In=F -> Out=1.
REQ-028 Hold: accept In=3 (Out=D), then in_valid=0 for 3 cycles with In toggling -> Out stays D, out_valid low after first cycle.
REQ-029 Reset: accept In=5, assert rst_n=0 with in_valid=1, In=2 -> Out=0, out_valid=0; release, accept In=2 -> Out=E next cycle.
REQ-030 Involution/width: WIDTH=8, random 1000 operands, feed Out back -> original value returned; In=0x80 -> ovf=1.
